// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file geometry and the operand fetch
// controller state encoding.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } opf_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard: one busy bit per architectural register.
// A set and a clear of the same bit in one cycle leaves the bit set, so an
// instruction that re-targets a register being written back keeps it pending.
module reg_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 1 << ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  input  logic [ADDR_W-1:0]   look_a_addr,
  input  logic [ADDR_W-1:0]   look_b_addr,
  input  logic [ADDR_W-1:0]   look_c_addr,
  output logic                busy_a,
  output logic                busy_b,
  output logic                busy_c,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Next busy vector: clear first, then set so that set has priority.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  // Busy vector register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_a   = busy_q[look_a_addr];
  assign busy_b   = busy_q[look_b_addr];
  assign busy_c   = busy_q[look_c_addr];
  assign busy_vec = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch controller between decode and execute.
// Accepts one decoded instruction, reads both register file ports in the
// accept cycle, registers the operands in READ and presents them in HOLD.
// Pending destinations are tracked in reg_scoreboard to stall RAW/WAW.
//
// Optional feature: define OPERAND_FETCH_FWD_EN to bypass a same-cycle
// writeback into a blocked source (and to let a same-cycle writeback clear a
// WAW block), releasing the stall one cycle earlier.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. ex_valid, once high, stays high with ex_* stable until
// ex_ready is seen; id_ready never depends on id_valid. wb_valid is always
// accepted.
module operand_fetch #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int INFO_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [ADDR_W-1:0]      id_rs1,
  input  logic [ADDR_W-1:0]      id_rs2,
  input  logic [ADDR_W-1:0]      id_rd,
  input  logic                   id_rd_we,
  input  logic [INFO_W-1:0]      id_info,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [XLEN-1:0]        ex_rs1_data,
  output logic [XLEN-1:0]        ex_rs2_data,
  output logic [ADDR_W-1:0]      ex_rd,
  output logic                   ex_rd_we,
  output logic [INFO_W-1:0]      ex_info,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  output logic                   rf_read_en1,
  output logic                   rf_read_en2,
  output logic [ADDR_W-1:0]      rf_read_addr1,
  output logic [ADDR_W-1:0]      rf_read_addr2,
  input  logic [XLEN-1:0]        rf_read_data1,
  input  logic [XLEN-1:0]        rf_read_data2,
  output logic                   rf_write_en,
  output logic [ADDR_W-1:0]      rf_write_addr,
  output logic [XLEN-1:0]        rf_write_data,
  output logic [1:0]             dbg_state_o,
  output logic [(1<<ADDR_W)-1:0] dbg_busy_o
);

  import cpu_pkg::*;

  opf_state_t          state_q;
  logic                ex_valid_q;
  logic [XLEN-1:0]     ex_rs1_q;
  logic [XLEN-1:0]     ex_rs2_q;
  logic [ADDR_W-1:0]   ex_rd_q;
  logic                ex_rd_we_q;
  logic [INFO_W-1:0]   ex_info_q;

  // Fields captured at accept, consumed in READ.
  logic [ADDR_W-1:0]   rs1_q;
  logic [ADDR_W-1:0]   rs2_q;
  logic [ADDR_W-1:0]   rd_q;
  logic                rd_we_q;
  logic [INFO_W-1:0]   info_q;

  logic                busy_rs1;
  logic                busy_rs2;
  logic                busy_rd;
  logic                wb_clr;
  logic                clr_rs1;
  logic                clr_rs2;
  logic                clr_rd;
  logic                haz_rs1;
  logic                haz_rs2;
  logic                haz_rd;
  logic                hazard;
  logic                slot_free;
  logic                accept;
  logic                sb_set;
  logic [XLEN-1:0]     op1;
  logic [XLEN-1:0]     op2;

`ifdef OPERAND_FETCH_FWD_EN
  logic                fwd1_q;
  logic                fwd2_q;
  logic [XLEN-1:0]     fwd_data_q;
`endif

  // A writeback to x0 is dropped and never touches the scoreboard.
  assign wb_clr  = wb_valid && (wb_rd != '0);
  assign clr_rs1 = wb_clr && (wb_rd == id_rs1);
  assign clr_rs2 = wb_clr && (wb_rd == id_rs2);
  assign clr_rd  = wb_clr && (wb_rd == id_rd);

  // Hazard detection; with forwarding a same-cycle writeback lifts the block.
  always_comb begin
    haz_rs1 = busy_rs1 && (id_rs1 != '0);
    haz_rs2 = busy_rs2 && (id_rs2 != '0);
    haz_rd  = id_rd_we && (id_rd != '0) && busy_rd;
`ifdef OPERAND_FETCH_FWD_EN
    haz_rs1 = haz_rs1 && !clr_rs1;
    haz_rs2 = haz_rs2 && !clr_rs2;
    haz_rd  = haz_rd  && !clr_rd;
`endif
    hazard  = haz_rs1 || haz_rs2 || haz_rd;
  end

  assign slot_free = (state_q == IDLE) || ((state_q == HOLD) && ex_ready);
  assign id_ready  = !rst && !hazard && slot_free;
  assign accept    = id_valid && id_ready;
  assign sb_set    = accept && id_rd_we && (id_rd != '0);

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (1 << ADDR_W)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_en      (sb_set),
    .set_addr    (id_rd),
    .clr_en      (wb_clr),
    .clr_addr    (wb_rd),
    .look_a_addr (id_rs1),
    .look_b_addr (id_rs2),
    .look_c_addr (id_rd),
    .busy_a      (busy_rs1),
    .busy_b      (busy_rs2),
    .busy_c      (busy_rd),
    .busy_vec    (dbg_busy_o)
  );

  // Both read ports are always enabled together, only in the accept cycle.
  assign rf_read_en1   = accept;
  assign rf_read_en2   = accept;
  assign rf_read_addr1 = id_rs1;
  assign rf_read_addr2 = id_rs2;

  assign rf_write_en   = wb_clr && !rst;
  assign rf_write_addr = wb_rd;
  assign rf_write_data = wb_data;

  // Operand selection in READ: x0 reads as zero, forwarded data wins over RF.
  always_comb begin
    op1 = rf_read_data1;
    op2 = rf_read_data2;
`ifdef OPERAND_FETCH_FWD_EN
    if (fwd1_q) op1 = fwd_data_q;
    if (fwd2_q) op2 = fwd_data_q;
`endif
    if (rs1_q == '0) op1 = '0;
    if (rs2_q == '0) op2 = '0;
  end

  // Controller FSM with registered execute-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ex_valid_q <= 1'b0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      ex_rd_we_q <= 1'b0;
      ex_info_q  <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      info_q     <= '0;
`ifdef OPERAND_FETCH_FWD_EN
      fwd1_q     <= 1'b0;
      fwd2_q     <= 1'b0;
      fwd_data_q <= '0;
`endif
    end else begin
      if (accept) begin
        rs1_q   <= id_rs1;
        rs2_q   <= id_rs2;
        rd_q    <= id_rd;
        rd_we_q <= id_rd_we;
        info_q  <= id_info;
`ifdef OPERAND_FETCH_FWD_EN
        fwd1_q     <= busy_rs1 && clr_rs1;
        fwd2_q     <= busy_rs2 && clr_rs2;
        fwd_data_q <= wb_data;
`endif
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= READ;
        end
        READ: begin
          ex_rs1_q   <= op1;
          ex_rs2_q   <= op2;
          ex_rd_q    <= rd_q;
          ex_rd_we_q <= rd_we_q;
          ex_info_q  <= info_q;
          ex_valid_q <= 1'b1;
          state_q    <= HOLD;
        end
        HOLD: begin
          if (ex_ready) begin
            ex_valid_q <= 1'b0;
            state_q    <= accept ? READ : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rs1_data = ex_rs1_q;
  assign ex_rs2_data = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rd_we    = ex_rd_we_q;
  assign ex_info     = ex_info_q;
  assign dbg_state_o = state_q;

endmodule
